// File: rtl/commit_trace_fifo_if.sv
// Trace drain bus between commit_trace_fifo and its trace/difftest consumer.
// The producer side holds the head entry stable until trace_ready accepts it.
interface commit_trace_fifo_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic [3:0]  trace_excType;
    logic [31:0] trace_seq;

    modport master (
        output trace_valid,
        input  trace_ready,
        output trace_pc,
        output trace_inst,
        output trace_excType,
        output trace_seq
    );

    modport slave (
        input  trace_valid,
        output trace_ready,
        input  trace_pc,
        input  trace_inst,
        input  trace_excType,
        input  trace_seq
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Retirement trace capture: sequence-tagged FIFO, retire/exception/drop
// statistics and a no-retire watchdog. Never back-pressures the pipeline.
module commit_trace_fifo #(
    parameter int DEPTH       = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     SI_EX_WB_ioValid,
    input  logic [31:0]              SI_EX_WB_pc,
    input  logic [31:0]              SI_EX_WB_inst,
    input  logic [3:0]               SI_EX_WB_excType,
    input  logic                     clear_sticky,
    commit_trace_fifo_if.master      trace,
    output logic [$clog2(DEPTH):0]   count,
    output logic [63:0]              retire_cnt,
    output logic [31:0]              exc_cnt,
    output logic [15:0]              drop_cnt,
    output logic                     overflow,
    output logic                     hang
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(WDOG_CYCLES);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);
    localparam logic [WW-1:0] WD_LIM   = WW'(WDOG_CYCLES - 2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
        logic [31:0] seq;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HUNG = 2'd2
    } wd_state_t;

    entry_t          mem [DEPTH];
    entry_t          head_e;
    entry_t          new_e;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [31:0]     seq_next;
    logic [WW-1:0]   wdog;
    wd_state_t       wd_state;

    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            do_drop;
    logic            is_exc;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_FULL);
        do_pop  = !empty && trace.trace_ready;
        do_push = SI_EX_WB_ioValid && (!full || do_pop);
        do_drop = SI_EX_WB_ioValid && full && !do_pop;
        is_exc  = (SI_EX_WB_excType != 4'd0);
        head_e  = mem[head];
        new_e   = '{pc:   SI_EX_WB_pc,
                    inst: SI_EX_WB_inst,
                    exc:  SI_EX_WB_excType,
                    seq:  seq_next};
    end

    // Outputs are forced to zero while empty so stale storage never leaks.
    assign trace.trace_valid   = !empty;
    assign trace.trace_pc      = empty ? 32'd0 : head_e.pc;
    assign trace.trace_inst    = empty ? 32'd0 : head_e.inst;
    assign trace.trace_excType = empty ? 4'd0  : head_e.exc;
    assign trace.trace_seq     = empty ? 32'd0 : head_e.seq;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= new_e;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_pop) begin
                head <= head + PTR_ONE;
            end
            if (do_push) begin
                tail <= tail + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Dropped retirements still consume a sequence number.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_next   <= '0;
            retire_cnt <= '0;
            exc_cnt    <= '0;
        end else if (SI_EX_WB_ioValid) begin
            seq_next   <= seq_next + 32'd1;
            retire_cnt <= retire_cnt + 64'd1;
            if (is_exc) begin
                exc_cnt <= exc_cnt + 32'd1;
            end
        end
    end

    // A drop in the same cycle as clear_sticky wins over the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (do_drop) begin
            overflow <= 1'b1;
            if (clear_sticky) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clear_sticky) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_state <= IDLE;
            wdog     <= '0;
            hang     <= 1'b0;
        end else begin
            unique case (wd_state)
                IDLE: begin
                    wdog <= '0;
                    if (SI_EX_WB_ioValid) begin
                        wd_state <= RUN;
                    end
                end
                RUN: begin
                    if (SI_EX_WB_ioValid || clear_sticky) begin
                        wdog <= '0;
                    end else if (wdog == WD_LIM) begin
                        wd_state <= HUNG;
                        wdog     <= wdog + WD_ONE;
                    end else begin
                        wdog <= wdog + WD_ONE;
                    end
                end
                HUNG: begin
                    if (SI_EX_WB_ioValid || clear_sticky) begin
                        wd_state <= RUN;
                        wdog     <= '0;
                    end
                end
                default: begin
                    wd_state <= IDLE;
                    wdog     <= '0;
                end
            endcase
            if (clear_sticky) begin
                hang <= 1'b0;
            end else if (wd_state == RUN && !SI_EX_WB_ioValid
                         && wdog == WD_LIM) begin
                hang <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomised and directed checks of commit_trace_fifo against a queue model.
// The model tracks entries, sequence numbers, statistics and idle-run length.
module tb_commit_trace_fifo;
    localparam int DEPTH = 8;
    localparam int WD    = 16;

    logic        clock;
    logic        reset;
    logic        SI_EX_WB_ioValid;
    logic [31:0] SI_EX_WB_pc;
    logic [31:0] SI_EX_WB_inst;
    logic [3:0]  SI_EX_WB_excType;
    logic        clear_sticky;
    logic [3:0]  count;
    logic [63:0] retire_cnt;
    logic [31:0] exc_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        hang;

    commit_trace_fifo_if tif();

    commit_trace_fifo #(.DEPTH(DEPTH), .WDOG_CYCLES(WD)) dut (
        .clock            (clock),
        .reset            (reset),
        .SI_EX_WB_ioValid (SI_EX_WB_ioValid),
        .SI_EX_WB_pc      (SI_EX_WB_pc),
        .SI_EX_WB_inst    (SI_EX_WB_inst),
        .SI_EX_WB_excType (SI_EX_WB_excType),
        .clear_sticky     (clear_sticky),
        .trace            (tif),
        .count            (count),
        .retire_cnt       (retire_cnt),
        .exc_cnt          (exc_cnt),
        .drop_cnt         (drop_cnt),
        .overflow         (overflow),
        .hang             (hang)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
        logic [31:0] seq;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_seq;
    logic [63:0] m_ret;
    logic [31:0] m_exc;
    int          m_drop;
    bit          m_over;
    bit          m_hang;
    bit          m_started;
    int          m_idle;
    int          chk;
    int          pass;

    task automatic model_clear();
        q.delete();
        m_seq = 0; m_ret = 0; m_exc = 0; m_drop = 0;
        m_over = 0; m_hang = 0; m_started = 0; m_idle = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        SI_EX_WB_ioValid = 1'b0;
        SI_EX_WB_pc = '0;
        SI_EX_WB_inst = '0;
        SI_EX_WB_excType = '0;
        clear_sticky = 1'b0;
        tif.trace_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // One clock of stimulus; the model advances by the spec's rules.
    task automatic drive_cycle(input bit iov, input logic [31:0] pc,
                               input logic [31:0] inst, input logic [3:0] exc,
                               input bit rdy, input bit clr);
        bit pop;
        bit drop;
        ent_t e;
        SI_EX_WB_ioValid = iov;
        SI_EX_WB_pc = pc;
        SI_EX_WB_inst = inst;
        SI_EX_WB_excType = exc;
        tif.trace_ready = rdy;
        clear_sticky = clr;
        pop  = (q.size() != 0) && rdy;
        drop = iov && (q.size() == DEPTH) && !pop;
        @(posedge clock);
        #1;
        if (pop) e = q.pop_front();
        if (iov) begin
            e = '{pc, inst, exc, m_seq};
            if (!drop) q.push_back(e);
            m_seq++;
            m_ret++;
            if (exc != 0) m_exc++;
        end
        if (clr) begin m_over = 0; m_drop = 0; m_hang = 0; end
        if (drop) begin m_over = 1; if (m_drop < 65535) m_drop++; end
        if (iov) begin
            m_started = 1; m_idle = 0;
        end else if (clr) begin
            m_idle = 0;
        end else if (m_started) begin
            m_idle++;
            if (m_idle == WD - 1) m_hang = 1;
        end
        SI_EX_WB_ioValid = 1'b0;
        clear_sticky = 1'b0;
        tif.trace_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk++; if (tif.trace_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", tif.trace_valid); else pass++;
        chk++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else pass++;
        chk++; if ({retire_cnt, exc_cnt, drop_cnt} !== '0) $display("FAIL reset_cnts got %h/%h/%h want 0", retire_cnt, exc_cnt, drop_cnt); else pass++;
        chk++; if ({overflow, hang} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", overflow, hang); else pass++;
        chk++; if ({tif.trace_pc, tif.trace_seq} !== 64'd0) $display("FAIL reset_head got %h/%h want 0", tif.trace_pc, tif.trace_seq); else pass++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 32'h8000_0000 + 32'(4 * i), $urandom, 0, 0, 0);
        chk++; if (count !== 4'd3) $display("FAIL basic_count got %0d want 3", count); else pass++;
        chk++; if (tif.trace_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", tif.trace_valid); else pass++;
        chk++; if (tif.trace_pc !== 32'h8000_0000) $display("FAIL basic_pc got %h want 80000000", tif.trace_pc); else pass++;
        for (int i = 0; i < 3; i++) begin
            chk++; if (tif.trace_seq !== 32'(i) || tif.trace_pc !== 32'h8000_0000 + 32'(4 * i))
                $display("FAIL basic_drain%0d got seq %0d pc %h want seq %0d", i, tif.trace_seq, tif.trace_pc, i); else pass++;
            drive_cycle(0, 0, 0, 0, 1, 0);
        end
        chk++; if (tif.trace_valid !== 1'b0) $display("FAIL basic_empty got %b want 0", tif.trace_valid); else pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1, 32'h100 + 32'(i), $urandom, 0, 0, 0);
        chk++; if (count !== 4'd8) $display("FAIL ovf_count got %0d want 8", count); else pass++;
        chk++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) $display("FAIL ovf_drop got %b/%0d want 1/2", overflow, drop_cnt); else pass++;
        chk++; if (retire_cnt !== 64'd10) $display("FAIL ovf_retire got %0d want 10", retire_cnt); else pass++;
        for (int i = 0; i < 8; i++) begin
            chk++; if (tif.trace_seq !== 32'(i)) $display("FAIL ovf_seq%0d got %0d want %0d", i, tif.trace_seq, i); else pass++;
            drive_cycle(0, 0, 0, 0, 1, 0);
        end
        drive_cycle(1, 32'h200, 0, 0, 0, 0);
        chk++; if (tif.trace_seq !== 32'd10) $display("FAIL ovf_next_seq got %0d want 10", tif.trace_seq); else pass++;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1, 32'h300 + 32'(i), 0, 0, 0, 0);
        drive_cycle(1, 32'h1234, 32'hABCD, 0, 1, 0);
        chk++; if (count !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 16'd0)
            $display("FAIL full_pp got cnt %0d ovf %b drop %0d want 8/0/0", count, overflow, drop_cnt); else pass++;
        for (int i = 1; i < 9; i++) begin
            if (i == 8) begin
                chk++; if (tif.trace_seq !== 32'd8 || tif.trace_pc !== 32'h1234)
                    $display("FAIL full_pp_last got seq %0d pc %h want 8/1234", tif.trace_seq, tif.trace_pc); else pass++;
            end
            drive_cycle(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_exc();
        logic [3:0] ex [4];
        ex[0] = 4'd0; ex[1] = 4'd2; ex[2] = 4'd0; ex[3] = 4'd11;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1, 32'(i), 0, ex[i], 0, 0);
        chk++; if (exc_cnt !== 32'd2) $display("FAIL exc_cnt got %0d want 2", exc_cnt); else pass++;
        for (int i = 0; i < 4; i++) begin
            chk++; if (tif.trace_excType !== ex[i]) $display("FAIL exc_type%0d got %0d want %0d", i, tif.trace_excType, ex[i]); else pass++;
            drive_cycle(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_wdog();
        do_reset();
        repeat (40) drive_cycle(0, 0, 0, 0, 0, 0);
        chk++; if (hang !== 1'b0) $display("FAIL wd_noretire got %b want 0", hang); else pass++;
        drive_cycle(1, 0, 0, 0, 1, 0);
        repeat (WD - 2) drive_cycle(0, 0, 0, 0, 1, 0);
        chk++; if (hang !== 1'b0) $display("FAIL wd_early got %b want 0", hang); else pass++;
        drive_cycle(0, 0, 0, 0, 1, 0);
        chk++; if (hang !== 1'b1) $display("FAIL wd_fire got %b want 1", hang); else pass++;
        drive_cycle(1, 0, 0, 0, 1, 0);
        chk++; if (hang !== 1'b1) $display("FAIL wd_sticky got %b want 1", hang); else pass++;
        drive_cycle(0, 0, 0, 0, 1, 1);
        chk++; if (hang !== 1'b0) $display("FAIL wd_clear got %b want 0", hang); else pass++;
        repeat (WD - 1) drive_cycle(0, 0, 0, 0, 1, 0);
        chk++; if (hang !== 1'b1) $display("FAIL wd_refire got %b want 1", hang); else pass++;
    endtask

    task automatic test_clear_drop();
        do_reset();
        for (int i = 0; i < 9; i++) drive_cycle(1, 32'(i), 0, 0, 0, 0);
        drive_cycle(1, 32'h99, 0, 0, 0, 1);
        chk++; if (overflow !== 1'b1 || drop_cnt !== 16'd1)
            $display("FAIL clr_drop got %b/%0d want 1/1", overflow, drop_cnt); else pass++;
        drive_cycle(0, 0, 0, 0, 0, 1);
        chk++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || count !== 4'd8)
            $display("FAIL clr_only got %b/%0d/%0d want 0/0/8", overflow, drop_cnt, count); else pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1, 32'h400 + 32'(i), 0, 4'd3, 0, 0);
        repeat (WD - 1) drive_cycle(0, 0, 0, 0, 0, 0);
        chk++; if (hang !== 1'b1 || count !== 4'd5) $display("FAIL ar_pre got hang %b cnt %0d want 1/5", hang, count); else pass++;
        #2 reset = 1'b0;
        #1;
        chk++; if ({tif.trace_valid, count, overflow, hang} !== '0)
            $display("FAIL ar_flags got v%b c%0d o%b h%b want 0", tif.trace_valid, count, overflow, hang); else pass++;
        chk++; if ({retire_cnt, exc_cnt} !== '0) $display("FAIL ar_cnts got %0d/%0d want 0", retire_cnt, exc_cnt); else pass++;
        @(posedge clock);
        #1 reset = 1'b1;
        model_clear();
        drive_cycle(1, 32'h500, 0, 0, 0, 0);
        chk++; if (tif.trace_seq !== 32'd0 || tif.trace_pc !== 32'h500)
            $display("FAIL ar_seq got %0d/%h want 0/500", tif.trace_seq, tif.trace_pc); else pass++;
    endtask

    task automatic test_random();
        int p_iov;
        int p_rdy;
        logic [100:0] got_h;
        logic [100:0] exp_h;
        logic [117:0] got_c;
        logic [117:0] exp_c;
        int prob [4];
        prob[0] = 0; prob[1] = 8; prob[2] = 50; prob[3] = 95;
        do_reset();
        p_iov = 50;
        p_rdy = 50;
        for (int i = 0; i < 1200; i++) begin
            if (i % 100 == 0) begin
                p_iov = prob[$urandom_range(0, 3)];
                p_rdy = prob[$urandom_range(1, 3)];
            end
            got_h = {tif.trace_valid, tif.trace_pc, tif.trace_inst, tif.trace_excType, tif.trace_seq};
            if (q.size() != 0) exp_h = {1'b1, q[0].pc, q[0].inst, q[0].exc, q[0].seq};
            else exp_h = '0;
            chk++; if (got_h !== exp_h) $display("FAIL rnd_head@%0d got %h want %h", i, got_h, exp_h); else pass++;
            drive_cycle($urandom_range(0, 99) < p_iov, $urandom, $urandom,
                        ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                        $urandom_range(0, 99) < p_rdy, $urandom_range(0, 63) == 0);
            got_c = {count, retire_cnt, exc_cnt, drop_cnt, overflow, hang};
            exp_c = {4'(q.size()), m_ret, m_exc, 16'(m_drop), m_over, m_hang};
            chk++; if (got_c !== exp_c) $display("FAIL rnd_cnt@%0d got %h want %h", i, got_c, exp_c); else pass++;
        end
    endtask

    initial begin
        chk = 0;
        pass = 0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_exc();
        test_wdog();
        test_clear_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
